// File: rtl/srcu_control_sequencer.sv
// Mini SRC control sequencer: fetch with memory handshake, decode and execute stepping.
// Optional fetch-hold IDLE state is enabled by defining CU_STOP_EN.
module srcu_control_sequencer #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        Mem_Done,
   input  logic        Stop,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic [12:0] AluOp,
   output logic [16:0] Ctl,
   output logic        Run,
   output logic        Fault
);

   localparam int CTL_PCOUT    = 0;
   localparam int CTL_PCIN     = 1;
   localparam int CTL_INCPC    = 2;
   localparam int CTL_MARIN    = 3;
   localparam int CTL_ZIN      = 4;
   localparam int CTL_ZLOWOUT  = 5;
   localparam int CTL_ZHIGHOUT = 6;
   localparam int CTL_MDRIN    = 7;
   localparam int CTL_MDROUT   = 8;
   localparam int CTL_READ     = 9;
   localparam int CTL_RAMREAD  = 10;
   localparam int CTL_IRIN     = 11;
   localparam int CTL_YIN      = 12;
   localparam int CTL_LOIN     = 13;
   localparam int CTL_LOOUT    = 14;
   localparam int CTL_HIIN     = 15;
   localparam int CTL_HIOUT    = 16;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_MUL  = 2;
   localparam int ALU_DIV  = 3;
   localparam int ALU_SHR  = 4;
   localparam int ALU_SHRA = 5;
   localparam int ALU_SHL  = 6;
   localparam int ALU_ROR  = 7;
   localparam int ALU_ROL  = 8;
   localparam int ALU_AND  = 9;
   localparam int ALU_OR   = 10;
   localparam int ALU_NEG  = 11;
   localparam int ALU_NOT  = 12;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

   typedef enum logic [3:0] {
      S_T0   = 4'd0,
      S_T1   = 4'd1,
      S_T2   = 4'd2,
      S_T3   = 4'd3,
      S_T4   = 4'd4,
      S_T5   = 4'd5,
      S_T6   = 4'd6,
      S_HALT = 4'd7
`ifdef CU_STOP_EN
      , S_IDLE = 4'd8
`endif
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_MULDIV, C_UNARY, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
   } cls_t;

   state_t      state, next_state;
   cls_t        cls;
   logic [12:0] alu_sel;
   logic [7:0]  wait_cnt;
   logic        timeout;
   logic        hold_fetch;
   logic [3:0]  ra, rb, rc;
   logic [15:0] rin_ra;
   logic        unused_ir;

   assign ra        = IR[26:23];
   assign rb        = IR[22:19];
   assign rc        = IR[18:15];
   assign unused_ir = ^IR[14:0];

   function automatic logic [15:0] onehot16(input logic [3:0] sel);
      onehot16 = 16'd1 << sel;
   endfunction

   // R0 is hard-wired, so a write aimed at it is simply dropped.
   assign rin_ra = onehot16(ra) & 16'hFFFE;

`ifdef CU_STOP_EN
   assign hold_fetch = Stop;
`else
   logic unused_stop;
   assign unused_stop = Stop;
   assign hold_fetch  = 1'b0;
`endif

   // Timeout fires on the cycle whose increment would bring the count to MEM_WAIT_MAX.
   assign timeout = (state == S_T1) && !Mem_Done && (wait_cnt == WAIT_LAST);

   // NOTE: every variable in a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      cls     = C_ILL;
      alu_sel = '0;
      case (IR[31:27])
         5'b00000: begin cls = C_ALU;    alu_sel[ALU_ADD]  = 1'b1; end
         5'b00001: begin cls = C_ALU;    alu_sel[ALU_SUB]  = 1'b1; end
         5'b00010: begin cls = C_ALU;    alu_sel[ALU_AND]  = 1'b1; end
         5'b00011: begin cls = C_ALU;    alu_sel[ALU_OR]   = 1'b1; end
         5'b00100: begin cls = C_ALU;    alu_sel[ALU_SHR]  = 1'b1; end
         5'b00101: begin cls = C_ALU;    alu_sel[ALU_SHRA] = 1'b1; end
         5'b00110: begin cls = C_ALU;    alu_sel[ALU_SHL]  = 1'b1; end
         5'b00111: begin cls = C_ALU;    alu_sel[ALU_ROR]  = 1'b1; end
         5'b01000: begin cls = C_ALU;    alu_sel[ALU_ROL]  = 1'b1; end
         5'b01111: begin cls = C_MULDIV; alu_sel[ALU_MUL]  = 1'b1; end
         5'b10000: begin cls = C_MULDIV; alu_sel[ALU_DIV]  = 1'b1; end
         5'b10001: begin cls = C_UNARY;  alu_sel[ALU_NEG]  = 1'b1; end
         5'b10010: begin cls = C_UNARY;  alu_sel[ALU_NOT]  = 1'b1; end
         5'b11000: cls = C_MFHI;
         5'b11001: cls = C_MFLO;
         5'b11010: cls = C_NOP;
         5'b11011: cls = C_HALT;
         default:  cls = C_ILL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state    <= S_T0;
         wait_cnt <= '0;
         Fault    <= 1'b0;
      end else begin
         state <= next_state;
         if (state != S_T1)
            wait_cnt <= '0;
         else if (!Mem_Done)
            wait_cnt <= wait_cnt + 8'd1;
         if (timeout || (state == S_T3 && cls == C_ILL))
            Fault <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_T0: begin
`ifdef CU_STOP_EN
            if (hold_fetch) next_state = S_IDLE;
            else            next_state = S_T1;
`else
            next_state = S_T1;
`endif
         end
         S_T1: begin
            if (Mem_Done)     next_state = S_T2;
            else if (timeout) next_state = S_HALT;
         end
         S_T2: next_state = S_T3;
         S_T3: begin
            case (cls)
               C_ALU, C_MULDIV, C_UNARY: next_state = S_T4;
               C_MFHI, C_MFLO, C_NOP:    next_state = S_T0;
               default:                  next_state = S_HALT;
            endcase
         end
         S_T4: next_state = (cls == C_UNARY)  ? S_T0 : S_T5;
         S_T5: next_state = (cls == C_MULDIV) ? S_T6 : S_T0;
         S_T6: next_state = S_T0;
`ifdef CU_STOP_EN
         S_IDLE: next_state = Stop ? S_IDLE : S_T0;
`endif
         default: next_state = S_HALT;
      endcase
   end

   always_comb begin
      Rin   = '0;
      Rout  = '0;
      AluOp = '0;
      Ctl   = '0;
      Run   = 1'b0;
      // Clear overrides everything, abandoning any instruction in flight.
      if (!Clear) begin
         Run = (state != S_HALT)
`ifdef CU_STOP_EN
               && (state != S_IDLE)
`endif
               ;
         case (state)
            S_T0: begin
               if (!hold_fetch) begin
                  Ctl[CTL_PCOUT] = 1'b1;
                  Ctl[CTL_MARIN] = 1'b1;
                  Ctl[CTL_INCPC] = 1'b1;
                  Ctl[CTL_ZIN]   = 1'b1;
               end
            end
            S_T1: begin
               Ctl[CTL_ZLOWOUT] = 1'b1;
               Ctl[CTL_RAMREAD] = 1'b1;
               Ctl[CTL_READ]    = 1'b1;
               Ctl[CTL_MDRIN]   = 1'b1;
               Ctl[CTL_PCIN]    = (wait_cnt == 8'd0);
            end
            S_T2: begin
               Ctl[CTL_MDROUT] = 1'b1;
               Ctl[CTL_IRIN]   = 1'b1;
            end
            S_T3: begin
               case (cls)
                  C_ALU:    begin Rout = onehot16(rb); Ctl[CTL_YIN] = 1'b1; end
                  C_MULDIV: begin Rout = onehot16(ra); Ctl[CTL_YIN] = 1'b1; end
                  C_UNARY:  begin Rout = onehot16(rb); AluOp = alu_sel; Ctl[CTL_ZIN] = 1'b1; end
                  C_MFHI:   begin Rin = rin_ra; Ctl[CTL_HIOUT] = 1'b1; end
                  C_MFLO:   begin Rin = rin_ra; Ctl[CTL_LOOUT] = 1'b1; end
                  default:  ;
               endcase
            end
            S_T4: begin
               case (cls)
                  C_ALU:    begin Rout = onehot16(rc); AluOp = alu_sel; Ctl[CTL_ZIN] = 1'b1; end
                  C_MULDIV: begin Rout = onehot16(rb); AluOp = alu_sel; Ctl[CTL_ZIN] = 1'b1; end
                  C_UNARY:  begin Rin = rin_ra; Ctl[CTL_ZLOWOUT] = 1'b1; end
                  default:  ;
               endcase
            end
            S_T5: begin
               Ctl[CTL_ZLOWOUT] = 1'b1;
               if (cls == C_MULDIV) Ctl[CTL_LOIN] = 1'b1;
               else                 Rin = rin_ra;
            end
            S_T6: begin
               Ctl[CTL_ZHIGHOUT] = 1'b1;
               Ctl[CTL_HIIN]     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_srcu_control_sequencer.sv
// Scoreboard bench for srcu_control_sequencer: the driver queues per-cycle expected strobes,
// a negedge monitor pops and compares them. Define CU_STOP_EN to exercise the fetch hold.
module tb_srcu_control_sequencer;

   logic        Clock, Clear, Mem_Done, Stop;
   logic [31:0] IR;
   logic [15:0] Rin, Rout;
   logic [12:0] AluOp;
   logic [16:0] Ctl;
   logic        Run, Fault;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [16:0] ctl;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [12:0] alu;
      logic        run;
      logic        flt;
      string       tag;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [16:0] CT_NONE  = 17'h00000;
   localparam logic [16:0] CT_T0    = 17'h0001D;
   localparam logic [16:0] CT_T1F   = 17'h006A2;
   localparam logic [16:0] CT_T1    = 17'h006A0;
   localparam logic [16:0] CT_T2    = 17'h00900;
   localparam logic [16:0] CT_YIN   = 17'h01000;
   localparam logic [16:0] CT_ZIN   = 17'h00010;
   localparam logic [16:0] CT_ZLO   = 17'h00020;
   localparam logic [16:0] CT_LOIN  = 17'h02020;
   localparam logic [16:0] CT_HIIN  = 17'h08040;
   localparam logic [16:0] CT_HIOUT = 17'h10000;
   localparam logic [16:0] CT_LOOUT = 17'h04000;

   srcu_control_sequencer #(.MEM_WAIT_MAX(15)) dut (
      .Clock    (Clock),
      .Clear    (Clear),
      .IR       (IR),
      .Mem_Done (Mem_Done),
      .Stop     (Stop),
      .Rin      (Rin),
      .Rout     (Rout),
      .AluOp    (AluOp),
      .Ctl      (Ctl),
      .Run      (Run),
      .Fault    (Fault)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
      mk_ir = {op, ra, rb, rc, 15'h0};
   endfunction

   // One clock cycle: drive Mem_Done, queue what the DUT must show, advance.
   task automatic cyc(input logic md, input logic [16:0] ctl, input logic [15:0] rin,
                      input logic [15:0] rout, input logic [12:0] alu, input logic run,
                      input logic flt, input string tag);
      exp_t e;
      Mem_Done = md;
      e.ctl = ctl; e.rin = rin; e.rout = rout; e.alu = alu;
      e.run = run; e.flt = flt; e.tag = tag;
      exp_q.push_back(e);
      @(posedge Clock);
      #1;
   endtask

   task automatic fetch(input int delay, input logic [31:0] ir, input string tag);
      IR = ir;
      cyc(1'b1, CT_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, {tag, "_t0"});
      for (int i = 0; i <= delay; i++)
         cyc(i == delay, (i == 0) ? CT_T1F : CT_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0,
             {tag, "_t1"});
      cyc(1'b0, CT_T2, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, {tag, "_t2"});
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge Clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({Ctl, Rin, Rout, AluOp, Run, Fault} !== {e.ctl, e.rin, e.rout, e.alu, e.run, e.flt}) begin
               errors++;
               $display("FAIL %s: got ctl=%h rin=%h rout=%h alu=%h run=%b fault=%b, want ctl=%h rin=%h rout=%h alu=%h run=%b fault=%b",
                        e.tag, Ctl, Rin, Rout, AluOp, Run, Fault,
                        e.ctl, e.rin, e.rout, e.alu, e.run, e.flt);
            end
         end
      end
   end

   initial begin
      Clear = 1'b1; Stop = 1'b0; Mem_Done = 1'b0; IR = '0;
      @(posedge Clock);
      #1;
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, "reset_a");
      cyc(1'b1, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, "reset_b");
      Clear = 1'b0;

      // add r3 = r4 + r7, memory ready at once: 6 cycles
      fetch(0, mk_ir(5'h00, 4'd3, 4'd4, 4'd7), "add");
      cyc(1'b0, CT_YIN, 16'h0,    16'h0010, 13'h0,    1'b1, 1'b0, "add_t3");
      cyc(1'b0, CT_ZIN, 16'h0,    16'h0080, 13'h0001, 1'b1, 1'b0, "add_t4");
      cyc(1'b0, CT_ZLO, 16'h0008, 16'h0,    13'h0,    1'b1, 1'b0, "add_t5");

      // mul r2, r5 with three cycles of memory delay: 10 cycles, PCin once
      fetch(3, mk_ir(5'h0F, 4'd2, 4'd5, 4'd0), "mul");
      cyc(1'b0, CT_YIN,  16'h0, 16'h0004, 13'h0,    1'b1, 1'b0, "mul_t3");
      cyc(1'b0, CT_ZIN,  16'h0, 16'h0020, 13'h0004, 1'b1, 1'b0, "mul_t4");
      cyc(1'b0, CT_LOIN, 16'h0, 16'h0,    13'h0,    1'b1, 1'b0, "mul_t5");
      cyc(1'b0, CT_HIIN, 16'h0, 16'h0,    13'h0,    1'b1, 1'b0, "mul_t6");

      // not with destination r0: write discarded
      fetch(0, mk_ir(5'h12, 4'd0, 4'd6, 4'd0), "not");
      cyc(1'b0, CT_ZIN, 16'h0, 16'h0040, 13'h1000, 1'b1, 1'b0, "not_t3");
      cyc(1'b0, CT_ZLO, 16'h0, 16'h0,    13'h0,    1'b1, 1'b0, "not_t4");

      // sub r15 = r1 - r0
      fetch(0, mk_ir(5'h01, 4'd15, 4'd1, 4'd0), "sub");
      cyc(1'b0, CT_YIN, 16'h0,    16'h0002, 13'h0,    1'b1, 1'b0, "sub_t3");
      cyc(1'b0, CT_ZIN, 16'h0,    16'h0001, 13'h0002, 1'b1, 1'b0, "sub_t4");
      cyc(1'b0, CT_ZLO, 16'h8000, 16'h0,    13'h0,    1'b1, 1'b0, "sub_t5");

      // or r5 = r2 | r3
      fetch(0, mk_ir(5'h03, 4'd5, 4'd2, 4'd3), "or");
      cyc(1'b0, CT_YIN, 16'h0,    16'h0004, 13'h0,    1'b1, 1'b0, "or_t3");
      cyc(1'b0, CT_ZIN, 16'h0,    16'h0008, 13'h0400, 1'b1, 1'b0, "or_t4");
      cyc(1'b0, CT_ZLO, 16'h0020, 16'h0,    13'h0,    1'b1, 1'b0, "or_t5");

      // div r1, r9
      fetch(0, mk_ir(5'h10, 4'd1, 4'd9, 4'd0), "div");
      cyc(1'b0, CT_YIN,  16'h0, 16'h0002, 13'h0,    1'b1, 1'b0, "div_t3");
      cyc(1'b0, CT_ZIN,  16'h0, 16'h0200, 13'h0008, 1'b1, 1'b0, "div_t4");
      cyc(1'b0, CT_LOIN, 16'h0, 16'h0,    13'h0,    1'b1, 1'b0, "div_t5");
      cyc(1'b0, CT_HIIN, 16'h0, 16'h0,    13'h0,    1'b1, 1'b0, "div_t6");

      // neg r12 = -r13
      fetch(0, mk_ir(5'h11, 4'd12, 4'd13, 4'd0), "neg");
      cyc(1'b0, CT_ZIN, 16'h0,    16'h2000, 13'h0800, 1'b1, 1'b0, "neg_t3");
      cyc(1'b0, CT_ZLO, 16'h1000, 16'h0,    13'h0,    1'b1, 1'b0, "neg_t4");

      // mfhi r4, mflo r9, nop
      fetch(0, mk_ir(5'h18, 4'd4, 4'd0, 4'd0), "mfhi");
      cyc(1'b0, CT_HIOUT, 16'h0010, 16'h0, 13'h0, 1'b1, 1'b0, "mfhi_t3");
      fetch(0, mk_ir(5'h19, 4'd9, 4'd0, 4'd0), "mflo");
      cyc(1'b0, CT_LOOUT, 16'h0200, 16'h0, 13'h0, 1'b1, 1'b0, "mflo_t3");
      fetch(0, mk_ir(5'h1A, 4'd0, 4'd0, 4'd0), "nop");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, "nop_t3");

`ifdef CU_STOP_EN
      // Stop raised mid-mul: instruction completes, then T0 holds and moves to IDLE
      fetch(0, mk_ir(5'h0F, 4'd2, 4'd5, 4'd0), "smul");
      Stop = 1'b1;
      cyc(1'b0, CT_YIN,  16'h0, 16'h0004, 13'h0,    1'b1, 1'b0, "smul_t3");
      cyc(1'b0, CT_ZIN,  16'h0, 16'h0020, 13'h0004, 1'b1, 1'b0, "smul_t4");
      cyc(1'b0, CT_LOIN, 16'h0, 16'h0,    13'h0,    1'b1, 1'b0, "smul_t5");
      cyc(1'b0, CT_HIIN, 16'h0, 16'h0,    13'h0,    1'b1, 1'b0, "smul_t6");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0,    13'h0,    1'b1, 1'b0, "stop_t0");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0,    13'h0,    1'b0, 1'b0, "idle_a");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0,    13'h0,    1'b0, 1'b0, "idle_b");
      Stop = 1'b0;
      cyc(1'b0, CT_NONE, 16'h0, 16'h0,    13'h0,    1'b0, 1'b0, "idle_release");
      fetch(0, mk_ir(5'h1A, 4'd0, 4'd0, 4'd0), "resume");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, "resume_t3");
`else
      // Stop has no effect in this build: T0 still executes
      Stop = 1'b1;
      fetch(0, mk_ir(5'h1A, 4'd0, 4'd0, 4'd0), "stopign");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, "stopign_t3");
      Stop = 1'b0;
`endif

      // Mem_Done arriving on the timeout cycle wins
      fetch(14, mk_ir(5'h1A, 4'd0, 4'd0, 4'd0), "late");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, "late_t3");

      // Clear mid-instruction abandons the add
      fetch(0, mk_ir(5'h00, 4'd6, 4'd1, 4'd2), "abort");
      cyc(1'b0, CT_YIN, 16'h0, 16'h0002, 13'h0,    1'b1, 1'b0, "abort_t3");
      cyc(1'b0, CT_ZIN, 16'h0, 16'h0004, 13'h0001, 1'b1, 1'b0, "abort_t4");
      Clear = 1'b1;
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, "abort_clear");
      Clear = 1'b0;

      // halt: HALT without fault, no exit except Clear
      fetch(0, mk_ir(5'h1B, 4'd0, 4'd0, 4'd0), "halt");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, "halt_t3");
      cyc(1'b1, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, "halt_a");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, "halt_b");
      Clear = 1'b1;
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, "halt_clear");
      Clear = 1'b0;

      // illegal opcode: HALT with Fault, Clear in that same cycle
      fetch(0, mk_ir(5'h1F, 4'd1, 4'd1, 4'd1), "ill");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, "ill_t3");
      Clear = 1'b1;
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, "ill_halt_clear");
      Clear = 1'b0;
      fetch(0, mk_ir(5'h19, 4'd9, 4'd0, 4'd0), "postill");
      cyc(1'b0, CT_LOOUT, 16'h0200, 16'h0, 13'h0, 1'b1, 1'b0, "postill_t3");

      // memory timeout: 15 cycles in T1 then HALT with Fault
      IR = mk_ir(5'h1A, 4'd0, 4'd0, 4'd0);
      cyc(1'b0, CT_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, "tmo_t0");
      cyc(1'b0, CT_T1F, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, "tmo_t1_first");
      for (int i = 1; i < 15; i++)
         cyc(1'b0, CT_T1, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, "tmo_t1_wait");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, "tmo_halt_a");
      cyc(1'b1, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, "tmo_halt_b");
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, "tmo_halt_c");
      Clear = 1'b1;
      cyc(1'b0, CT_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, "tmo_clear");
      Clear = 1'b0;
      cyc(1'b1, CT_T0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, "tmo_restart_t0");

      repeat (2) @(negedge Clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
